// File: rtl/zigzag_quantizer.sv
// Zig-zag reorder and reciprocal quantiser for 8x8 DCT blocks.
// Ping-pong coefficient banks feed a 4-stage read pipeline with valid/ready on both sides.
module zigzag_quantizer #(
  parameter int IN_WIDTH    = 14,
  parameter int OUT_WIDTH   = 11,
  parameter int RECIP_WIDTH = 17,
  parameter int RECIP_FRAC  = 16
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic                   I_en,
  input  logic                   I_valid,
  output logic                   O_ready,
  input  logic [IN_WIDTH-1:0]    I_coef,
  input  logic                   I_yc,
  input  logic                   I_tbl_we,
  input  logic [6:0]             I_tbl_addr,
  input  logic [RECIP_WIDTH-1:0] I_tbl_data,
  output logic                   O_valid,
  input  logic                   I_ready,
  output logic [OUT_WIDTH-1:0]   O_coef,
  output logic [5:0]             O_index,
  output logic                   O_first,
  output logic                   O_last,
  output logic                   O_yc
);

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_DRAINING = 2'd3;

  localparam int PW = IN_WIDTH + RECIP_WIDTH + 1;
  localparam logic [PW-1:0]        ONE_W     = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]        HALF_W    = ONE_W << (RECIP_FRAC - 1);
  localparam logic [PW-1:0]        MAG_MAX_W = {{(PW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MAG_MAX   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] ONE_O     = {{(OUT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [5:0] zz_addr(input logic [5:0] k);
    logic [5:0] r;
    case (k)
      6'd0:  r = 6'd0;  6'd1:  r = 6'd1;  6'd2:  r = 6'd8;  6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;  6'd5:  r = 6'd2;  6'd6:  r = 6'd3;  6'd7:  r = 6'd10;
      6'd8:  r = 6'd17; 6'd9:  r = 6'd24; 6'd10: r = 6'd32; 6'd11: r = 6'd25;
      6'd12: r = 6'd18; 6'd13: r = 6'd11; 6'd14: r = 6'd4;  6'd15: r = 6'd5;
      6'd16: r = 6'd12; 6'd17: r = 6'd19; 6'd18: r = 6'd26; 6'd19: r = 6'd33;
      6'd20: r = 6'd40; 6'd21: r = 6'd48; 6'd22: r = 6'd41; 6'd23: r = 6'd34;
      6'd24: r = 6'd27; 6'd25: r = 6'd20; 6'd26: r = 6'd13; 6'd27: r = 6'd6;
      6'd28: r = 6'd7;  6'd29: r = 6'd14; 6'd30: r = 6'd21; 6'd31: r = 6'd28;
      6'd32: r = 6'd35; 6'd33: r = 6'd42; 6'd34: r = 6'd49; 6'd35: r = 6'd56;
      6'd36: r = 6'd57; 6'd37: r = 6'd50; 6'd38: r = 6'd43; 6'd39: r = 6'd36;
      6'd40: r = 6'd29; 6'd41: r = 6'd22; 6'd42: r = 6'd15; 6'd43: r = 6'd23;
      6'd44: r = 6'd30; 6'd45: r = 6'd37; 6'd46: r = 6'd44; 6'd47: r = 6'd51;
      6'd48: r = 6'd58; 6'd49: r = 6'd59; 6'd50: r = 6'd52; 6'd51: r = 6'd45;
      6'd52: r = 6'd38; 6'd53: r = 6'd31; 6'd54: r = 6'd39; 6'd55: r = 6'd46;
      6'd56: r = 6'd53; 6'd57: r = 6'd60; 6'd58: r = 6'd61; 6'd59: r = 6'd54;
      6'd60: r = 6'd47; 6'd61: r = 6'd55; 6'd62: r = 6'd62; 6'd63: r = 6'd63;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  logic [IN_WIDTH-1:0]    coef_mem [128];
  logic [RECIP_WIDTH-1:0] recip_tbl [128];

  logic [1:0] bank_st_r [2];
  logic [1:0] bank_yc_r;
  logic       wr_bank_r;
  logic [5:0] wr_ptr_r;
  logic       rd_active_r, rd_bank_r, rd_next_r;
  logic [5:0] rd_k_r;

  logic       s1_v_r, s2_v_r, s3_v_r;
  logic [5:0] s1_k_r, s2_k_r, s3_k_r;
  logic       s1_yc_r, s2_yc_r, s3_yc_r;
  logic [IN_WIDTH-1:0]    s1_coef_r, s2_coef_r;
  logic [RECIP_WIDTH-1:0] s2_recip_r;
  logic [PW-1:0]          s3_prod_r;

  logic wr_fire_s, stall_s, adv_s, claim_s, issue_s, free_s, iss_bank_s;
  logic [5:0] iss_k_s;
  logic [PW-1:0] coef_ext_s, recip_ext_s, abs_s, rnd_s;
  logic neg_s;
  logic [OUT_WIDTH-1:0] mag_s, q_s;

  assign O_ready    = (bank_st_r[wr_bank_r] == ST_EMPTY) || (bank_st_r[wr_bank_r] == ST_FILLING);
  assign wr_fire_s  = I_en & I_valid & O_ready;
  // The whole read pipeline freezes while the output word is refused.
  assign stall_s    = O_valid & ~I_ready;
  assign adv_s      = I_en & ~stall_s;
  assign claim_s    = adv_s & ~rd_active_r & (bank_st_r[rd_next_r] == ST_FULL);
  assign issue_s    = (adv_s & rd_active_r) | claim_s;
  assign free_s     = adv_s & rd_active_r & (rd_k_r == 6'd63);
  assign iss_bank_s = rd_active_r ? rd_bank_r : rd_next_r;
  assign iss_k_s    = rd_active_r ? rd_k_r : 6'd0;

  assign coef_ext_s  = {{(PW-IN_WIDTH){s2_coef_r[IN_WIDTH-1]}}, s2_coef_r};
  assign recip_ext_s = {{(PW-RECIP_WIDTH){1'b0}}, s2_recip_r};

  always_comb begin
    neg_s = s3_prod_r[PW-1];
    if (neg_s) abs_s = ~s3_prod_r + ONE_W;
    else       abs_s = s3_prod_r;
    rnd_s = (abs_s + HALF_W) >> RECIP_FRAC;
    if (rnd_s > MAG_MAX_W) mag_s = MAG_MAX;
    else                   mag_s = rnd_s[OUT_WIDTH-1:0];
    if (neg_s) q_s = ~mag_s + ONE_O;
    else       q_s = mag_s;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int b = 0; b < 2; b++) bank_st_r[b] <= ST_EMPTY;
      bank_yc_r <= 2'b00;
      wr_bank_r <= 1'b0;
      wr_ptr_r  <= 6'd0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_fire_s && wr_bank_r == 1'(b))
          bank_st_r[b] <= (wr_ptr_r == 6'd63) ? ST_FULL : ST_FILLING;
        else if (claim_s && rd_next_r == 1'(b))
          bank_st_r[b] <= ST_DRAINING;
        else if (free_s && rd_bank_r == 1'(b))
          bank_st_r[b] <= ST_EMPTY;
        if (wr_fire_s && wr_bank_r == 1'(b) && wr_ptr_r == 6'd0)
          bank_yc_r[b] <= I_yc;
      end
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + 6'd1;
        if (wr_ptr_r == 6'd63) wr_bank_r <= ~wr_bank_r;
      end
    end
  end

  // Banks are claimed strictly in fill order, so rd_next_r simply alternates.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rd_active_r <= 1'b0;
      rd_bank_r   <= 1'b0;
      rd_next_r   <= 1'b0;
      rd_k_r      <= 6'd0;
    end else if (issue_s) begin
      if (claim_s) begin
        rd_active_r <= 1'b1;
        rd_bank_r   <= rd_next_r;
        rd_next_r   <= ~rd_next_r;
        rd_k_r      <= 6'd1;
      end else if (rd_k_r == 6'd63) begin
        rd_active_r <= 1'b0;
        rd_k_r      <= 6'd0;
      end else begin
        rd_k_r <= rd_k_r + 6'd1;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (wr_fire_s) coef_mem[{wr_bank_r, wr_ptr_r}] <= I_coef;
    if (I_en && I_tbl_we) recip_tbl[I_tbl_addr] <= I_tbl_data;
  end

  // Coefficient is captured at issue, so a freed bank may be refilled immediately.
  always_ff @(posedge I_clk) begin
    if (adv_s) begin
      s1_coef_r  <= coef_mem[{iss_bank_s, zz_addr(iss_k_s)}];
      s2_coef_r  <= s1_coef_r;
      s2_recip_r <= recip_tbl[{s1_yc_r, s1_k_r}];
      s3_prod_r  <= coef_ext_s * recip_ext_s;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s1_v_r  <= 1'b0; s2_v_r  <= 1'b0; s3_v_r  <= 1'b0;
      s1_k_r  <= 6'd0; s2_k_r  <= 6'd0; s3_k_r  <= 6'd0;
      s1_yc_r <= 1'b0; s2_yc_r <= 1'b0; s3_yc_r <= 1'b0;
      O_valid <= 1'b0;
      O_coef  <= {OUT_WIDTH{1'b0}};
      O_index <= 6'd0;
      O_first <= 1'b0;
      O_last  <= 1'b0;
      O_yc    <= 1'b0;
    end else if (adv_s) begin
      s1_v_r  <= issue_s;
      s1_k_r  <= iss_k_s;
      s1_yc_r <= bank_yc_r[iss_bank_s];
      s2_v_r  <= s1_v_r;
      s2_k_r  <= s1_k_r;
      s2_yc_r <= s1_yc_r;
      s3_v_r  <= s2_v_r;
      s3_k_r  <= s2_k_r;
      s3_yc_r <= s2_yc_r;
      O_valid <= s3_v_r;
      O_coef  <= q_s;
      O_index <= s3_k_r;
      O_first <= s3_v_r & (s3_k_r == 6'd0);
      O_last  <= s3_v_r & (s3_k_r == 6'd63);
      O_yc    <= s3_yc_r;
    end
  end

endmodule

// File: tb/tb_zigzag_quantizer.sv
// Randomised bench for zigzag_quantizer against a diagonal-walk / integer-arithmetic model.
module tb_zigzag_quantizer;

  localparam int IW = 14;
  localparam int OW = 11;
  localparam int RW = 17;
  localparam int RF = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_s = 1'b1;
  logic          up_valid_s = 1'b0;
  logic          up_ready_s;
  logic [IW-1:0] up_coef_s = '0;
  logic          up_yc_s = 1'b0;
  logic          tbl_we_s = 1'b0;
  logic [6:0]    tbl_addr_s = 7'd0;
  logic [RW-1:0] tbl_data_s = '0;
  logic          dn_valid_s;
  logic          dn_ready_s = 1'b1;
  logic [OW-1:0] dn_coef_s;
  logic [5:0]    dn_index_s;
  logic          dn_first_s, dn_last_s, dn_yc_s;

  zigzag_quantizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .RECIP_WIDTH(RW), .RECIP_FRAC(RF)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_en(en_s),
    .I_valid(up_valid_s), .O_ready(up_ready_s), .I_coef(up_coef_s), .I_yc(up_yc_s),
    .I_tbl_we(tbl_we_s), .I_tbl_addr(tbl_addr_s), .I_tbl_data(tbl_data_s),
    .O_valid(dn_valid_s), .I_ready(dn_ready_s), .O_coef(dn_coef_s), .O_index(dn_index_s),
    .O_first(dn_first_s), .O_last(dn_last_s), .O_yc(dn_yc_s)
  );

  always #5 clk = ~clk;

  typedef struct { int coef; int idx; int yc; } exp_t;
  typedef struct { int coef; int idx; int first; int last; int yc; longint cyc; } obs_t;

  int     zz_tbl [64];
  int     tbl_m [128];
  int     blk [64];
  exp_t   exp_q [$];
  obs_t   obs_q [$];
  int     chk_idx = 0;
  int     checks_cnt = 0;
  int     errors_cnt = 0;
  int     ready_wait_cnt = 0;
  longint cyc = 0;
  longint acc63_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer that the next rising edge will perform.
  always @(negedge clk) begin
    obs_t o;
    if (dn_valid_s && dn_ready_s && en_s) begin
      o.coef  = int'($signed(dn_coef_s));
      o.idx   = int'(dn_index_s);
      o.first = int'(dn_first_s);
      o.last  = int'(dn_last_s);
      o.yc    = int'(dn_yc_s);
      o.cyc   = cyc;
      obs_q.push_back(o);
    end
  end

  task automatic check_value(input string tag, input longint got, input longint exp);
    checks_cnt++;
    if (got != exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 8) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz_tbl[k] = r * 8 + (s - r); k++; end
      else            for (int r = lo; r <= hi; r++) begin zz_tbl[k] = r * 8 + (s - r); k++; end
    end
  endfunction

  function automatic int quant(int c, int r);
    longint p, a, m;
    longint lim = (longint'(1) << (OW - 1)) - 1;
    p = longint'(c) * longint'(r);
    a = (p < 0) ? -p : p;
    m = (a + (longint'(1) << (RF - 1))) >>> RF;
    if (m > lim) m = lim;
    return (p < 0) ? -int'(m) : int'(m);
  endfunction

  function automatic int rand_coef();
    return int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW - 1));
  endfunction

  task automatic load_tbl(input bit rnd, input int fixed);
    for (int a = 0; a < 128; a++) begin
      tbl_m[a] = rnd ? int'($urandom_range(0, (1 << RW) - 1)) : fixed;
      if (rnd && (a % 17 == 0)) tbl_m[a] = 0;
      tbl_we_s = 1'b1; tbl_addr_s = 7'(a); tbl_data_s = RW'(tbl_m[a]);
      @(posedge clk); #1;
    end
    tbl_we_s = 1'b0;
  endtask

  task automatic send_block(input bit yc, input int ncoef);
    if (ncoef == 64)
      for (int k = 0; k < 64; k++) begin
        exp_t e;
        e.coef = quant(blk[zz_tbl[k]], tbl_m[int'(yc) * 64 + k]);
        e.idx  = k;
        e.yc   = int'(yc);
        exp_q.push_back(e);
      end
    for (int n = 0; n < ncoef; n++) begin
      int t = 0;
      up_valid_s = 1'b1; up_coef_s = IW'(blk[n]); up_yc_s = yc;
      @(negedge clk);
      while (!up_ready_s && t < 1000) begin ready_wait_cnt++; t++; @(negedge clk); end
      if (t >= 1000) check_value("input_timeout", t, 0);
      @(posedge clk); #1;
      if (n == 63) acc63_cyc = cyc;
    end
    up_valid_s = 1'b0;
  endtask

  task automatic compare_outputs();
    check_value("out_count", obs_q.size(), exp_q.size());
    for (int i = chk_idx; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_value("coef",  obs_q[i].coef,  exp_q[i].coef);
      check_value("index", obs_q[i].idx,   exp_q[i].idx);
      check_value("first", obs_q[i].first, exp_q[i].idx == 0);
      check_value("last",  obs_q[i].last,  exp_q[i].idx == 63);
      check_value("yc",    obs_q[i].yc,    exp_q[i].yc);
    end
    chk_idx = exp_q.size();
  endtask

  task automatic wait_drain();
    int t = 0;
    while (obs_q.size() < exp_q.size() && t < 3000) begin @(posedge clk); t++; end
    repeat (8) @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_valid"}, dn_valid_s, 0);
    check_value({tag, "_coef"},  dn_coef_s,  0);
    check_value({tag, "_index"}, dn_index_s, 0);
    check_value({tag, "_first"}, dn_first_s, 0);
    check_value({tag, "_last"},  dn_last_s,  0);
    check_value({tag, "_yc"},    dn_yc_s,    0);
    check_value({tag, "_ready"}, up_ready_s, 1);
  endtask

  initial begin
    int base;
    build_zz();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp with unity reciprocals: zig-zag order and 4-edge latency.
    load_tbl(1'b0, 65536);
    for (int n = 0; n < 64; n++) blk[n] = n;
    base = obs_q.size();
    send_block(1'b0, 64);
    wait_drain();
    if (obs_q.size() > base) check_value("latency", obs_q[base].cyc - acc63_cyc, 4);
    else                     check_value("latency_missing", obs_q.size(), base + 1);

    // Half reciprocal: round half away from zero, with an I_en freeze mid-drain.
    load_tbl(1'b0, 32768);
    for (int n = 0; n < 64; n++) begin
      int picks [4] = '{3, -3, 1, -1};
      blk[n] = (n % 2 == 0) ? picks[$urandom_range(0, 3)] : rand_coef();
    end
    blk[0] = 3; blk[1] = -3; blk[8] = 1; blk[16] = -1;
    send_block(1'b1, 64);
    repeat (10) @(posedge clk);
    #1; en_s = 1'b0;
    repeat (7) @(posedge clk);
    #1; en_s = 1'b1;
    wait_drain();

    // Saturation at both extremes.
    load_tbl(1'b0, 65536);
    for (int n = 0; n < 64; n++) blk[n] = rand_coef();
    blk[0] = 8191; blk[1] = -8192;
    send_block(1'b0, 64);
    wait_drain();

    // Three back-to-back blocks with distinct random tables: gap-free, O_ready steady.
    load_tbl(1'b1, 0);
    ready_wait_cnt = 0;
    base = obs_q.size();
    for (int b = 0; b < 3; b++) begin
      for (int n = 0; n < 64; n++) blk[n] = rand_coef();
      send_block(b[0], 64);
    end
    wait_drain();
    check_value("ready_steady", ready_wait_cnt, 0);
    if (obs_q.size() >= base + 192) check_value("gap_free", obs_q[base + 191].cyc - obs_q[base].cyc, 191);
    else                            check_value("burst_short", obs_q.size(), base + 192);

    // Downstream stall of 70 cycles mid-drain while input keeps arriving.
    ready_wait_cnt = 0;
    base = obs_q.size();
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          for (int n = 0; n < 64; n++) blk[n] = rand_coef();
          send_block(b[0], 64);
        end
      end
      begin
        int t = 0;
        while (obs_q.size() < base + 20 && t < 2000) begin @(posedge clk); t++; end
        #1; dn_ready_s = 1'b0;
        repeat (70) @(posedge clk);
        #1; dn_ready_s = 1'b1;
      end
    join
    wait_drain();
    check_value("ready_fell", ready_wait_cnt > 0, 1);

    // Reset at n=30 of a block while the previous one is draining.
    for (int n = 0; n < 64; n++) blk[n] = rand_coef();
    send_block(1'b1, 64);
    for (int n = 0; n < 64; n++) blk[n] = rand_coef();
    send_block(1'b0, 30);
    rst_n = 1'b0;
    @(negedge clk);
    while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
    check_reset_outputs("rst_mid");
    compare_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 64; n++) blk[n] = rand_coef();
    send_block(1'b1, 64);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/zigzag_quantizer.md
# zigzag_quantizer

Parametrised zig-zag reorder and quantisation stage between the 2-D DCT and the entropy coder. It accepts one 8×8 block of signed DCT coefficients in raster order and emits the block in zig-zag order. Each coefficient is multiplied by a run-time programmable reciprocal quantisation factor, rounded and saturated. Ping-pong buffering gives full 1-coefficient/cycle throughput, with valid/ready backpressure on both sides.

## Interface
Parameters:
- IN_WIDTH, 14: signed DCT coefficient width.
- OUT_WIDTH, 11: signed quantised coefficient width.
- RECIP_WIDTH, 17: unsigned reciprocal table entry width.
- RECIP_FRAC, 16: fractional bits of reciprocal; 2^RECIP_FRAC equals 1.0.

Ports:
- I_clk, in, 1: clock.
- I_rst_n, in, 1: reset, asynchronous, active-low.
- I_en, in, 1: global clock enable; low freezes all state and outputs.
- I_valid, in, 1: input coefficient valid.
- O_ready, out, 1: block can accept input; transfer when I_valid & O_ready & I_en.
- I_coef, in, IN_WIDTH: coefficient, raster order (row-major, n=0..63).
- I_yc, in, 1: component select (0 luma, 1 chroma); sampled on the transfer of n=0 only.
- I_tbl_we, in, 1: reciprocal table write strobe.
- I_tbl_addr, in, 7: {component, zig-zag index k}.
- I_tbl_data, in, RECIP_WIDTH: reciprocal value.
- O_valid, out, 1: output coefficient valid.
- I_ready, in, 1: downstream ready; transfer when O_valid & I_ready & I_en.
- O_coef, out, OUT_WIDTH: quantised coefficient, zig-zag order.
- O_index, out, 6: zig-zag position k of O_coef.
- O_first / O_last, out, 1 each: asserted with k=0 and k=63 respectively.
- O_yc, out, 1: component of the current output block.

## Operation
- Two 64-entry banks, each with a state of EMPTY, FILLING, FULL or DRAINING.
  - Write pointer n (0..63) selects the address; the bank toggles after n=63.
  - The read side steps k 0..63 through a 64-entry zig-zag ROM (k→raster address).
  - A bank becomes FULL on accepting n=63, then DRAINING when the read side claims it, then EMPTY after k=63 is issued.
- O_ready = 1 when the write-target bank is EMPTY or FILLING. It is 0 only when both banks are FULL/DRAINING.
- Each bank stores its own latched I_yc. O_yc and the table lookup use the draining bank's value.
- Reciprocal table: 128×RECIP_WIDTH RAM, read at {yc, k}.
  - It has no reset value; software must load all entries before the first block.
  - A write during a drain of the same component takes effect at the next read of that address; the bench must not rely on ordering within a block.
- Arithmetic:
  - p = I_coef × recip, signed × unsigned, full width IN_WIDTH+RECIP_WIDTH.
  - m = (|p| + 2^(RECIP_FRAC-1)) >> RECIP_FRAC, i.e. round half away from zero. The sign is then restored.
  - Saturate to ±(2^(OUT_WIDTH-1)-1); -2^(OUT_WIDTH-1) is never emitted.
  - recip = 0 gives 0.
- Read pipeline:
  - 4 stages: address issue, RAM+table read, multiply register, round/saturate output register.
  - When O_valid & !I_ready, the whole read pipeline stalls and holds. No coefficient is dropped or duplicated.
- I_en = 0: no transfers, no state change, outputs held. Table writes are also gated by I_en.
- Reset mid-block: partial blocks in both banks are discarded, and both banks return to EMPTY.

## Timing
- Reset values: O_valid=0, O_coef=0, O_index=0, O_first=0, O_last=0, O_yc=0, O_ready=1.
- Latency: with the other bank not draining and I_ready=1, O_valid for k=0 asserts on the 4th rising edge after the edge that accepts n=63.
- Throughput: continuous input of consecutive blocks with I_ready held high sustains 1 coefficient/cycle in and out, with O_ready never dropping.
- A block's output is 64 consecutive O_valid cycles when unstalled. The next block's k=0 follows its k=63 with no gap when that bank is already FULL.
- Simultaneous events:
  - Filling the last slot of one bank while draining k=63 of the other is legal.
  - The freed bank is writable on the next cycle, so O_ready rises one cycle after k=63 is issued.

## Test plan
- Load all reciprocals with 65536 (1.0), send the raster ramp I_coef=n -> O_coef follows the zig-zag order 0,1,8,16,9,2,…,63; O_first on k=0, O_last on k=63; first O_valid exactly 4 cycles after n=63 is accepted.
- Reciprocal 32768 (0.5), coefficients +3, -3, +1, -1 -> outputs +2, -2, +1, -1 (half away from zero).
- Coefficient 8191 with reciprocal 65536 and OUT_WIDTH=11 -> output +1023. Coefficient -8192 -> -1023.
- Three back-to-back blocks (luma, chroma, luma) with distinct tables and I_ready=1 -> gap-free output, correct table per block, O_yc = 0,1,0; O_ready stays 1.
- Hold I_ready=0 for 70 cycles mid-drain while input continues -> O_ready falls after the second bank fills; on release, output resumes at the held k without loss; all 64×3 coefficients match the reference model.
- Assert I_rst_n low at input n=30 -> all outputs return to reset values, O_ready=1. The next full block is output correctly with no residue.
